io_var_atten_sequencer: RTL and testbench
=========================================

IO_VAR_ATTEN_SEQUENCER -- requirements
Module: io_var_atten_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of attenuator channels sequenced.
REQ-002 SHALL have parameter DEPTH, default 8, number of step-table entries; power of two.
REQ-003 SHALL have parameter TW, default 32, delay/duration width in clocks.
REQ-004 SHALL have clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have cfg_we  in  1  step-table write strobe.
REQ-007 SHALL have cfg_addr  in  log2(DEPTH)  step index to write.
REQ-008 SHALL have cfg_mask  in  N_CH  channels fired by the step.
REQ-009 SHALL have cfg_delay, cfg_duration  in  TW each  per-step delay and pulse duration.
REQ-010 SHALL have n_steps  in  log2(DEPTH)+1  steps to run, sampled at start.
REQ-011 SHALL have start, abort  in  1 each  single-cycle commands.
REQ-012 SHALL have ch_complete  in  N_CH  per-channel completion flags.
REQ-013 SHALL have ch_mark, ch_go, ch_rst  out  N_CH each  per-channel arm, trigger, and active-high channel clear.
REQ-014 SHALL have ch_delay, ch_duration  out  TW each  shared buses to all channels.
REQ-015 SHALL have busy, done, aborted, wr_err  out  1 each; step_idx  out  log2(DEPTH)  current step.

Function
REQ-016 SHALL implement states IDLE, LOAD, ARM1, ARM2, FIRE, CLEAR, DONE.
REQ-017 IDLE: on start with n_steps>0, clear step_idx to 0 and go to LOAD; with n_steps==0, go straight to DONE.
REQ-018 LOAD: drive ch_delay/ch_duration from table[step_idx] for one cycle; if mask==0, skip to CLEAR with no channel activity; else go to ARM1.
REQ-019 ARM1, ARM2: ch_mark=mask and ch_go=0; one cycle each, so the channel sets its mark and then latches delay/duration.
REQ-020 FIRE: ch_mark=ch_go=mask, held until (ch_complete & mask)==mask; the next cycle is CLEAR.
REQ-021 CLEAR: ch_rst=mask for exactly one cycle with ch_mark=ch_go=0; then step_idx+1; go to LOAD if step_idx+1<n_steps, else DONE.
REQ-022 DONE: pulse done for one cycle, then IDLE.
REQ-023 ch_delay/ch_duration SHALL hold the current step's values from LOAD through CLEAR.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort in any non-IDLE state SHALL win over all other events: next cycle ch_rst=all ones for one cycle, ch_mark=ch_go=0, aborted=1, then IDLE without done; aborted clears on the next accepted start.
REQ-027 cfg_we while busy SHALL NOT write the table and SHALL pulse wr_err for one cycle.
REQ-028 cfg_we in IDLE SHALL write one entry per cycle; start and cfg_we in the same IDLE cycle: the write completes first, and the run uses the new entry.
REQ-029 ch_complete bits outside the mask SHALL be ignored.
REQ-030 n_steps>DEPTH SHALL be clamped to DEPTH.

Reset
REQ-031 On rst low: state=IDLE, step_idx=0, all ch_* outputs 0, busy=done=aborted=wr_err=0.
REQ-032 Table contents are not reset; entries read as don't-care until written.
REQ-033 Reset mid-run SHALL drop ch_mark/ch_go immediately (asynchronously), without any ch_rst pulse.

Configuration
REQ-034 Macro IOVA_SEQ_LOOP_EN, when defined: adds input loop_cnt[15:0], sampled at start. The full step list repeats loop_cnt+1 times, with the LOAD of step 0 following the final CLEAR; done pulses only after the last pass.
REQ-035 Without IOVA_SEQ_LOOP_EN: no loop_cnt port, and the list runs exactly once.

Structure
REQ-036 Package iova_seq_pkg SHALL hold the state encodings and the default N_CH/DEPTH/TW constants.
REQ-037 Step storage SHALL be sub-module iova_seq_table: one synchronous write port and one asynchronous read port, width N_CH+2*TW.

Verification
REQ-038 Step0 = mask 0001, delay 3, duration 5; n_steps=1; start -> ch_mark[0] high 2 cycles, then ch_go[0] high until complete; ch_rst[0] for 1 cycle; done 1 cycle later.
REQ-039 Steps 0..2 with masks 0011/0100/1000; complete[0] arrives 4 cycles after complete[1] -> step 0 leaves FIRE only after both are set; step_idx sequence 0,1,2.
REQ-040 Abort asserted 2 cycles into FIRE of step 1 -> ch_rst=1111 for one cycle, aborted=1, no done, busy low the cycle after.
REQ-041 cfg_we during a run -> wr_err pulses and the table read-back is unchanged; a step with mask 0000 -> no ch_mark activity, LOAD->CLEAR->next.
REQ-042 With IOVA_SEQ_LOOP_EN, loop_cnt=2 and 2 steps -> 6 CLEAR cycles, then a single done pulse.
REQ-043 rst low during ARM2 -> all outputs 0 in the same cycle; state IDLE after release.

Source files
------------

// File: rtl/iova_seq_pkg.sv
// Shared types and default sizing for the variable-attenuator step sequencer.
// Holds the FSM state encoding and the default N_CH / DEPTH / TW constants.
package iova_seq_pkg;

  localparam int IOVA_N_CH  = 4;
  localparam int IOVA_DEPTH = 8;
  localparam int IOVA_TW    = 32;

  // S_ABORT is the one-cycle all-channel clear that follows an abort.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM1,
    S_ARM2,
    S_FIRE,
    S_CLEAR,
    S_DONE,
    S_ABORT
  } seq_state_e;

  // States in which the shared delay/duration buses carry the step.
  function automatic logic bus_state(seq_state_e s);
    return (s == S_LOAD) || (s == S_ARM1) || (s == S_ARM2) ||
           (s == S_FIRE) || (s == S_CLEAR);
  endfunction

endpackage

// File: rtl/iova_seq_table.sv
// Step table: DEPTH entries of {mask, delay, duration}, no reset.
// Ports: i_clk, i_we/i_waddr/i_wdata (sync write), i_raddr/o_rdata (async read).
module iova_seq_table
  import iova_seq_pkg::*;
#(
  parameter int N_CH  = IOVA_N_CH,
  parameter int DEPTH = IOVA_DEPTH,
  parameter int TW    = IOVA_TW
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [N_CH+2*TW-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [N_CH+2*TW-1:0]       o_rdata
);

  logic [N_CH+2*TW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/io_var_atten_sequencer.sv
// Steps a table of {channel mask, delay, duration} entries through a group
// of attenuator channels: arm (mark), latch, fire (go), wait for complete,
// clear. Ports: clk, rst (async active-low), cfg_* table write, n_steps,
// start/abort, ch_complete in; ch_mark/ch_go/ch_rst, ch_delay/ch_duration,
// busy/done/aborted/wr_err, step_idx out.
// Build option IOVA_SEQ_LOOP_EN adds loop_cnt: the list repeats loop_cnt+1
// times before done.
module io_var_atten_sequencer
  import iova_seq_pkg::*;
#(
  parameter int N_CH  = IOVA_N_CH,
  parameter int DEPTH = IOVA_DEPTH,
  parameter int TW    = IOVA_TW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(DEPTH)-1:0]  cfg_addr,
  input  logic [N_CH-1:0]           cfg_mask,
  input  logic [TW-1:0]             cfg_delay,
  input  logic [TW-1:0]             cfg_duration,
  input  logic [$clog2(DEPTH):0]    n_steps,
  input  logic                      start,
  input  logic                      abort,
`ifdef IOVA_SEQ_LOOP_EN
  input  logic [15:0]               loop_cnt,
`endif
  input  logic [N_CH-1:0]           ch_complete,
  output logic [N_CH-1:0]           ch_mark,
  output logic [N_CH-1:0]           ch_go,
  output logic [N_CH-1:0]           ch_rst,
  output logic [TW-1:0]             ch_delay,
  output logic [TW-1:0]             ch_duration,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      wr_err,
  output logic [$clog2(DEPTH)-1:0]  step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = N_CH + 2*TW;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  seq_state_e      r_state;
  logic [AW-1:0]   r_step_idx;
  logic [AW:0]     r_nsteps;
  logic [N_CH-1:0] r_ch_mark;
  logic [N_CH-1:0] r_ch_go;
  logic [N_CH-1:0] r_ch_rst;
  logic            r_done;
  logic            r_aborted;
  logic            r_wr_err;
`ifdef IOVA_SEQ_LOOP_EN
  logic [15:0]     r_loop_left;
`endif

  logic            w_busy;
  logic            w_tbl_we;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_rdata;
  logic [N_CH-1:0] w_mask;
  logic [TW-1:0]   w_dly;
  logic [TW-1:0]   w_dur;
  logic [AW:0]     w_nsteps;
  logic [AW:0]     w_idx_inc;
  logic            w_last;
  logic            w_all_cpl;

  assign w_busy   = (r_state != S_IDLE);
  // The table is frozen for the whole run.
  assign w_tbl_we = cfg_we & ~w_busy;
  assign w_wdata  = {cfg_mask, cfg_delay, cfg_duration};

  iova_seq_table #(
    .N_CH  (N_CH),
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_table (
    .i_clk   (clk),
    .i_we    (w_tbl_we),
    .i_waddr (cfg_addr),
    .i_wdata (w_wdata),
    .i_raddr (r_step_idx),
    .o_rdata (w_rdata)
  );

  assign w_mask = w_rdata[DW-1 -: N_CH];
  assign w_dly  = w_rdata[2*TW-1 -: TW];
  assign w_dur  = w_rdata[TW-1:0];

  assign w_nsteps  = (n_steps > LP_DEPTH) ? LP_DEPTH : n_steps;
  assign w_idx_inc = {1'b0, r_step_idx} + LP_ONE;
  assign w_last    = (w_idx_inc >= r_nsteps);
  // Only the channels this step fired have to report.
  assign w_all_cpl = ((ch_complete & w_mask) == w_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_step_idx <= '0;
      r_nsteps   <= '0;
      r_ch_mark  <= '0;
      r_ch_go    <= '0;
      r_ch_rst   <= '0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_wr_err   <= 1'b0;
`ifdef IOVA_SEQ_LOOP_EN
      r_loop_left <= '0;
`endif
    end else begin
      r_wr_err <= cfg_we & w_busy;
      if (w_busy && abort) begin
        r_state   <= S_ABORT;
        r_ch_mark <= '0;
        r_ch_go   <= '0;
        r_ch_rst  <= '1;
        r_done    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_aborted <= 1'b0;
              r_nsteps  <= w_nsteps;
`ifdef IOVA_SEQ_LOOP_EN
              r_loop_left <= loop_cnt;
`endif
              if (n_steps == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_step_idx <= '0;
                r_state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (w_mask == '0) begin
              r_state <= S_CLEAR;
            end else begin
              r_state   <= S_ARM1;
              r_ch_mark <= w_mask;
            end
          end
          S_ARM1: begin
            r_state <= S_ARM2;
          end
          S_ARM2: begin
            r_state <= S_FIRE;
            r_ch_go <= w_mask;
          end
          S_FIRE: begin
            if (w_all_cpl) begin
              r_state   <= S_CLEAR;
              r_ch_mark <= '0;
              r_ch_go   <= '0;
              r_ch_rst  <= w_mask;
            end
          end
          S_CLEAR: begin
            r_ch_rst <= '0;
            if (!w_last) begin
              r_step_idx <= w_idx_inc[AW-1:0];
              r_state    <= S_LOAD;
            end else begin
`ifdef IOVA_SEQ_LOOP_EN
              if (r_loop_left != '0) begin
                r_loop_left <= r_loop_left - 16'd1;
                r_step_idx  <= '0;
                r_state     <= S_LOAD;
              end else begin
                r_step_idx <= w_idx_inc[AW-1:0];
                r_state    <= S_DONE;
                r_done     <= 1'b1;
              end
`else
              r_step_idx <= w_idx_inc[AW-1:0];
              r_state    <= S_DONE;
              r_done     <= 1'b1;
`endif
            end
          end
          S_DONE: begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ABORT: begin
            r_ch_rst <= '0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ch_mark     = r_ch_mark;
  assign ch_go       = r_ch_go;
  assign ch_rst      = r_ch_rst;
  assign ch_delay    = bus_state(r_state) ? w_dly : '0;
  assign ch_duration = bus_state(r_state) ? w_dur : '0;
  assign busy        = w_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign wr_err      = r_wr_err;
  assign step_idx    = r_step_idx;

endmodule

// File: tb/tb_io_var_atten_sequencer.sv
// Randomized bench for io_var_atten_sequencer against a step-list model.
// Expected per-cycle outputs are built from the step plan, then replayed.
module tb_io_var_atten_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_mask;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_duration;
  logic [3:0]  n_steps;
  logic        start;
  logic        abort;
`ifdef IOVA_SEQ_LOOP_EN
  logic [15:0] loop_cnt;
`endif
  logic [3:0]  ch_complete;
  logic [3:0]  ch_mark;
  logic [3:0]  ch_go;
  logic [3:0]  ch_rst;
  logic [31:0] ch_delay;
  logic [31:0] ch_duration;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        wr_err;
  logic [2:0]  step_idx;

  always #5 clk = ~clk;

  io_var_atten_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_mask     (cfg_mask),
    .cfg_delay    (cfg_delay),
    .cfg_duration (cfg_duration),
    .n_steps      (n_steps),
    .start        (start),
    .abort        (abort),
`ifdef IOVA_SEQ_LOOP_EN
    .loop_cnt     (loop_cnt),
`endif
    .ch_complete  (ch_complete),
    .ch_mark      (ch_mark),
    .ch_go        (ch_go),
    .ch_rst       (ch_rst),
    .ch_delay     (ch_delay),
    .ch_duration  (ch_duration),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .wr_err       (wr_err),
    .step_idx     (step_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model of the step table and of the state that survives between runs.
  logic [3:0]  m_mask [8];
  logic [31:0] m_dly  [8];
  logic [31:0] m_dur  [8];
  logic [2:0]  m_idx  = '0;
  bit          m_abrt = 1'b0;
  int          fl [8];

  typedef struct {
    logic [3:0]  mark, go, crst;
    logic        bsy, dn, abrt, werr;
    logic [2:0]  idx;
    bit          bus;
    logic [31:0] dly, dur;
    logic [3:0]  cpl;
    bit          we;
    logic [2:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd, wu;
    bit          st;
    logic [3:0]  sn;
    bit          ab;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [18:0] ctl_dut();
    return {ch_mark, ch_go, ch_rst, busy, done, aborted, wr_err, step_idx};
  endfunction

  function automatic logic [18:0] ctl_exp(cyc_t c);
    return {c.mark, c.go, c.crst, c.bsy, c.dn, c.abrt, c.werr, c.idx};
  endfunction

  // One step as seen from outside: LOAD, [ARM, ARM, FIRE x flen], CLEAR.
  task automatic push_step(input int s, input int flen, input bit noise);
    logic [3:0] m, low;
    cyc_t c;
    m   = m_mask[s];
    low = m & (~m + 4'd1);
    c = '{default: '0};
    c.bsy = 1'b1;
    c.idx = s[2:0];
    c.bus = 1'b1;
    c.dly = m_dly[s];
    c.dur = m_dur[s];
    c.cpl = noise ? 4'($urandom) : 4'h0;
    q.push_back(c);
    if (m != 4'h0) begin
      c.mark = m;
      for (int k = 0; k < 2; k++) begin
        c.cpl = noise ? 4'($urandom) : 4'h0;
        q.push_back(c);
      end
      c.go = m;
      for (int j = 1; j <= flen; j++) begin
        if (j < flen)
          c.cpl = noise ? ((4'($urandom) & m & ~low) | (4'($urandom) & ~m))
                        : (m & ~low);
        else
          c.cpl = m | (noise ? (4'($urandom) & ~m) : 4'h0);
        q.push_back(c);
      end
      c.mark = '0;
      c.go   = '0;
    end
    c.crst = m;
    c.cpl  = noise ? 4'($urandom) : 4'h0;
    q.push_back(c);
  endtask

  task automatic wr(input int a, input logic [3:0] m,
                    input logic [31:0] d, input logic [31:0] u);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a[2:0];
    cfg_mask = m; cfg_delay = d; cfg_duration = u;
    m_mask[a] = m; m_dly[a] = d; m_dur[a] = u;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("wr_err_idle", {63'd0, wr_err}, 64'd0);
  endtask

  task automatic run(input int ns_in, input int loops, input int abort_at,
                     input bit noise, input bit wr0, input string tag);
    int ns, passes;
    cyc_t c;
    logic [2:0] fin;
    bit was_ab;
    ns = (ns_in > 8) ? 8 : ns_in;
`ifdef IOVA_SEQ_LOOP_EN
    passes = loops + 1;
`else
    passes = 1 + (loops & 0);
`endif
    @(posedge clk); #1;
    start   = 1'b1;
    n_steps = 4'(ns_in);
    abort   = noise ? 1'($urandom) : 1'b0;
    ch_complete = 4'h0;
`ifdef IOVA_SEQ_LOOP_EN
    loop_cnt = 16'(loops);
`endif
    cfg_we = wr0;
    if (wr0) begin
      cfg_addr = 3'd0;
      cfg_mask = 4'($urandom);
      cfg_delay = $urandom;
      cfg_duration = $urandom;
      m_mask[0] = cfg_mask; m_dly[0] = cfg_delay; m_dur[0] = cfg_duration;
    end
    q.delete();
    if (ns == 0) begin
      c = '{default: '0};
      c.bsy = 1'b1; c.dn = 1'b1; c.idx = m_idx;
      q.push_back(c);
    end else begin
      for (int p = 0; p < passes; p++)
        for (int s = 0; s < ns; s++)
          push_step(s, noise ? int'($urandom_range(1, 4)) : fl[s], noise);
      c = '{default: '0};
      c.bsy = 1'b1; c.dn = 1'b1; c.idx = 3'(ns % 8);
      q.push_back(c);
    end
    was_ab = 1'b0;
    if (abort_at >= 0 && abort_at < q.size()) begin
      fin = q[abort_at].idx;
      while (q.size() > abort_at + 1) void'(q.pop_back());
      q[abort_at].ab = 1'b1;
      c = '{default: '0};
      c.bsy = 1'b1; c.abrt = 1'b1; c.crst = 4'hF; c.idx = fin;
      q.push_back(c);
      was_ab = 1'b1;
    end
    fin = q[q.size()-1].idx;
    c = '{default: '0};
    c.idx  = fin;
    c.abrt = was_ab;
    q.push_back(c);
    // Commands issued while busy must be ignored (writes flag wr_err).
    if (noise)
      for (int i = 0; i < q.size() - 1; i++) begin
        q[i].st = ($urandom_range(0, 3) == 0);
        q[i].sn = 4'($urandom);
        q[i].we = ($urandom_range(0, 2) == 0);
        q[i].wa = 3'($urandom);
        q[i].wm = 4'($urandom);
        q[i].wd = $urandom;
        q[i].wu = $urandom;
      end
    for (int i = 1; i < q.size(); i++) q[i].werr = q[i-1].we;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      start = q[i].st; n_steps = q[i].sn; abort = q[i].ab;
      cfg_we = q[i].we; cfg_addr = q[i].wa; cfg_mask = q[i].wm;
      cfg_delay = q[i].wd; cfg_duration = q[i].wu;
      ch_complete = q[i].cpl;
      @(negedge clk);
      chk({tag, "_ctl"}, 64'(ctl_dut()), 64'(ctl_exp(q[i])));
      if (q[i].bus) begin
        chk({tag, "_dly"}, 64'(ch_delay), 64'(q[i].dly));
        chk({tag, "_dur"}, 64'(ch_duration), 64'(q[i].dur));
      end
    end
    m_idx  = fin;
    m_abrt = was_ab;
  endtask

  task automatic reset_in_arm2();
    wr(0, 4'b0101, 32'd7, 32'd9);
    @(posedge clk); #1;
    start = 1'b1; n_steps = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arm2_mark", 64'(ch_mark), 64'h5);
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", 64'(ctl_dut()), 64'd0);
    chk("rst_async_dly", 64'(ch_delay), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_idle_ctl", 64'(ctl_dut()), 64'd0);
    m_idx  = '0;
    m_abrt = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0;
    cfg_delay = '0; cfg_duration = '0;
    n_steps = '0; start = 1'b0; abort = 1'b0; ch_complete = '0;
`ifdef IOVA_SEQ_LOOP_EN
    loop_cnt = '0;
`endif
    for (int i = 0; i < 8; i++) fl[i] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 64'(ctl_dut()), 64'd0);
    chk("reset_dly", 64'(ch_delay), 64'd0);
    chk("reset_dur", 64'(ch_duration), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      wr(i, 4'($urandom), $urandom, $urandom);

    // Single channel, single step.
    wr(0, 4'b0001, 32'd3, 32'd5);
    fl[0] = 3;
    run(1, 0, -1, 1'b0, 1'b0, "single");

    // Channel 1 completes four cycles before channel 0.
    wr(0, 4'b0011, 32'd10, 32'd11);
    wr(1, 4'b0100, 32'd20, 32'd21);
    wr(2, 4'b1000, 32'd30, 32'd31);
    fl[0] = 5; fl[1] = 2; fl[2] = 1;
    run(3, 0, -1, 1'b0, 1'b0, "three");

    // Abort two cycles into FIRE of step 1.
    fl[1] = 4;
    run(3, 0, 13, 1'b0, 1'b0, "abort");

    // Empty step plus writes attempted during the run.
    wr(1, 4'b0000, 32'd40, 32'd41);
    run(3, 0, -1, 1'b1, 1'b0, "busywr");
    run(3, 0, -1, 1'b0, 1'b0, "after");

    run(0, 0, -1, 1'b0, 1'b0, "zero");
    run(2, 0, -1, 1'b0, 1'b1, "startwr");
    run(13, 0, -1, 1'b1, 1'b0, "clamp");

`ifdef IOVA_SEQ_LOOP_EN
    run(2, 2, -1, 1'b0, 1'b0, "loop");
`endif

    reset_in_arm2();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        wr($urandom_range(0, 7), 4'($urandom), $urandom, $urandom);
      run($urandom_range(0, 15), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
          1'b1, 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
